wb_port_arbiter: RTL and testbench

- Shares one pipelined Wishbone memory port between the core's instruction port (m0) and data port (m1).
- Used when the second memory is disabled, so a single Controller memory interface must serve both fetches and loads/stores.
- Grants one master at a time and keeps one transaction outstanding.
- Registers the request toward the slave, routes the returned data/ack back to the owning master, and aborts hung transactions with a timeout error.

---
 rtl/wb_port_arbiter.sv | 103 ++++++++++
 tb/tb_wb_port_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one pipelined Wishbone slave port between instruction (m0) and data (m1) masters
module wb_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_ack
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t r_state, w_next;
  logic        r_last;
  logic [31:0] r_cnt;
  logic        w_req0, w_req1, w_start, w_sel1, w_done, w_tmo;
  assign w_req0 = m0_cyc & m0_stb;
  assign w_req1 = m1_cyc & m1_stb;
  always_comb begin
    // a completion pulse still showing means this cycle is the mandatory gap
    w_start = (r_state == IDLE) & ~(m0_ack | m1_ack | m0_err | m1_err) & (w_req0 | w_req1);
    w_sel1  = w_req1 & (~w_req0 | (FIXED_PRIORITY != 0) | ~r_last);
    w_done  = ((r_state == REQ) | (r_state == WAIT)) & s_ack;
    w_tmo   = (TIMEOUT_CYCLES != 0) & (r_state == WAIT) & ~s_ack & (r_cnt == 32'(TIMEOUT_CYCLES - 1));
    w_next  = w_start ? REQ : (w_done | w_tmo) ? IDLE : (r_state == REQ) ? WAIT : r_state;
  end
  always_ff @(posedge clk_core)
    if (rst_core) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_last   <= 1'b1;
      r_cnt    <= '0;
      s_cyc    <= 1'b0;
      s_stb    <= 1'b0;
      s_we     <= 1'b0;
      s_sel    <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_rdata <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      if (w_start) begin
        r_last  <= w_sel1;
        s_cyc   <= 1'b1;
        s_stb   <= 1'b1;
        s_we    <= w_sel1 ? m1_we : m0_we;
        s_sel   <= w_sel1 ? m1_sel : m0_sel;
        s_addr  <= w_sel1 ? m1_addr : m0_addr;
        s_wdata <= w_sel1 ? m1_wdata : m0_wdata;
      end
      if (r_state == REQ) s_stb <= 1'b0;
      if (r_state == WAIT) r_cnt <= r_cnt + 32'd1;
      if (w_done | w_tmo) begin
        s_cyc <= 1'b0;
        s_stb <= 1'b0;
        r_cnt <= '0;
        if (r_last) begin
          m1_ack   <= w_done;
          m1_err   <= w_tmo;
          m1_rdata <= w_done ? s_rdata : '0;
        end else begin
          m0_ack   <= w_done;
          m0_err   <= w_tmo;
          m0_rdata <= w_done ? s_rdata : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of a round-robin (a) and a fixed-priority (b) arbiter on shared stimulus
module tb_wb_port_arbiter;
  logic        clk = 0, rst = 1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] s_rdata = 0;
  logic        s_ack = 0;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
  logic [3:0]  a_s_sel, b_s_sel;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_port_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(4)) dut_a (
    .clk_core(clk), .rst_core(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_sel(a_s_sel), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack));
  wb_port_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(4)) dut_b (
    .clk_core(clk), .rst_core(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_sel(b_s_sel), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [31:0] rr_addr [4];
    rr_addr = '{32'h10, 32'h20, 32'h10, 32'h20};
    tick(); tick();
    chk("rst s_cyc", {31'd0, a_s_cyc}, 0);
    chk("rst s_stb", {31'd0, a_s_stb}, 0);
    chk("rst s_addr", a_s_addr, 0);
    chk("rst m0_ack", {31'd0, a_m0_ack}, 0);
    chk("rst m1_err", {31'd0, a_m1_err}, 0);
    chk("rst m0_rdata", a_m0_rdata, 0);
    rst = 0;
    // single read from m0, slave answers two cycles after s_stb
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100; m0_sel = 4'hF;
    tick();
    chk("rd s_cyc", {31'd0, a_s_cyc}, 1);
    chk("rd s_stb", {31'd0, a_s_stb}, 1);
    chk("rd s_addr", a_s_addr, 32'h100);
    chk("rd s_we", {31'd0, a_s_we}, 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("rd stb drop", {31'd0, a_s_stb}, 0);
    chk("rd cyc held", {31'd0, a_s_cyc}, 1);
    tick();
    chk("rd no early ack", {31'd0, a_m0_ack}, 0);
    s_ack = 1; s_rdata = 32'hA5A5_0001;
    tick();
    chk("rd m0_ack", {31'd0, a_m0_ack}, 1);
    chk("rd m0_rdata", a_m0_rdata, 32'hA5A5_0001);
    chk("rd m1_ack", {31'd0, a_m1_ack}, 0);
    chk("rd s_cyc off", {31'd0, a_s_cyc}, 0);
    s_ack = 0;
    tick();
    chk("rd ack 1cyc", {31'd0, a_m0_ack}, 0);
    chk("rd rdata hold", a_m0_rdata, 32'hA5A5_0001);
    // write from m1 with a zero-wait slave
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011; m1_addr = 32'h2004; m1_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr s_we", {31'd0, a_s_we}, 1);
    chk("wr s_sel", {28'd0, a_s_sel}, 4'b0011);
    chk("wr s_wdata", a_s_wdata, 32'hDEAD_BEEF);
    chk("wr s_addr", a_s_addr, 32'h2004);
    m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 1;
    tick();
    chk("wr m1_ack", {31'd0, a_m1_ack}, 1);
    chk("wr m0_ack", {31'd0, a_m0_ack}, 0);
    chk("wr m1_rdata", a_m1_rdata, 32'hA5A5_0001);
    s_ack = 0;
    tick();
    // both request continuously: a alternates, b always picks m1
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10; m0_we = 0;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h20; m1_we = 0;
    s_ack = 1; s_rdata = 32'h0000_1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d s_addr", i), a_s_addr, rr_addr[i]);
      chk($sformatf("fp%0d s_addr", i), b_s_addr, 32'h20);
      tick();
      chk($sformatf("rr%0d m0_ack", i), {31'd0, a_m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d m1_ack", i), {31'd0, a_m1_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("rr%0d idle gap", i), {31'd0, a_s_cyc}, 0);
    end
    m1_cyc = 0; m1_stb = 0;
    tick();
    chk("fp m0 after m1 drop", b_s_addr, 32'h10);
    tick();
    chk("fp m0_ack", {31'd0, b_m0_ack}, 1);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    // hung slave: abort after four WAIT cycles
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h300;
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick(); tick(); tick(); tick();
    chk("to not yet", {31'd0, a_m0_err}, 0);
    chk("to cyc held", {31'd0, a_s_cyc}, 1);
    chk("to prior rdata", a_m0_rdata, 32'h0000_1111);
    tick();
    chk("to m0_err", {31'd0, a_m0_err}, 1);
    chk("to m0_rdata", a_m0_rdata, 0);
    chk("to s_cyc", {31'd0, a_s_cyc}, 0);
    chk("to m0_ack", {31'd0, a_m0_ack}, 0);
    s_ack = 1;
    tick();
    chk("late ack m0_ack", {31'd0, a_m0_ack}, 0);
    chk("late ack m0_err", {31'd0, a_m0_err}, 0);
    chk("late ack s_cyc", {31'd0, a_s_cyc}, 0);
    s_ack = 0;
    // reset in WAIT after an m0 grant; tie afterwards must go to m0 again
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h400;
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mrst s_cyc", {31'd0, a_s_cyc}, 0);
    chk("mrst s_addr", a_s_addr, 0);
    chk("mrst m0_err", {31'd0, a_m0_err}, 0);
    chk("mrst m1_rdata", a_m1_rdata, 0);
    s_ack = 1;
    tick();
    chk("mrst late m0_ack", {31'd0, a_m0_ack}, 0);
    chk("mrst late s_cyc", {31'd0, a_s_cyc}, 0);
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h20;
    tick();
    chk("post rst tie a", a_s_addr, 32'h10);
    chk("post rst tie b", b_s_addr, 32'h20);
    chk("post rst s_stb", {31'd0, a_s_stb}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
